piano_voice_ctrl: RTL

- Voice-allocation controller between the eight piano keys (t0..t7) and a bank of NUM_VOICES divfreq tone generators.
- Detects key press and release events and assigns each pressed key to a free voice.
- Configures the assigned voice with that note's divider value over a req/ack handshake, and frees the voice when the key is released.
- The downstream mixer (SUM/PLAY stage) uses active_mask to know which voices contribute to wave.

---
 rtl/piano_pkg.sv | 14 +
 rtl/piano_prio_enc.sv | 21 ++
 rtl/piano_voice_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/piano_pkg.sv
// Shared constants, FSM state type and note divider table for the piano voice controller.
package piano_pkg;
    localparam int NUM_KEYS  = 8;
    localparam int KEY_W     = $clog2(NUM_KEYS);
    localparam int DIV_TBL_W = 18;

    typedef enum logic [1:0] {IDLE, FIND, REQ} state_t;

    // Half-period dividers for a 50 MHz clock, C4 .. C5.
    localparam logic [DIV_TBL_W-1:0] DIV_TABLE [NUM_KEYS] = '{
        18'd95555, 18'd85132, 18'd75843, 18'd71586,
        18'd63776, 18'd56818, 18'd50619, 18'd47778
    };
endpackage

// File: rtl/piano_prio_enc.sv
// Lowest-set-bit priority encoder with a found flag.
module piano_prio_enc #(
    parameter int W  = 8,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          found
);
    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Scan high to low so the lowest set bit wins.
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/piano_voice_ctrl.sv
// Voice allocator: maps key press/release events onto a bank of shared tone
// generators, one req/ack configuration transaction per event.
module piano_voice_ctrl #(
    parameter int NUM_KEYS   = piano_pkg::NUM_KEYS,
    parameter int NUM_VOICES = 4,
    parameter int DIV_W      = piano_pkg::DIV_TBL_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_KEYS-1:0]           keys,
    output logic                          voice_req,
    output logic [$clog2(NUM_VOICES)-1:0] voice_idx,
    output logic [DIV_W-1:0]              voice_div,
    output logic                          voice_gate,
    input  logic                          voice_ack,
    output logic [NUM_VOICES-1:0]         active_mask,
    output logic                          busy,
    output logic                          dropped
);
    import piano_pkg::*;

    localparam int KW = $clog2(NUM_KEYS);
    localparam int VW = $clog2(NUM_VOICES);

    state_t                         state;
    logic [NUM_KEYS-1:0]            keys_q;
    logic [NUM_KEYS-1:0]            held;
    logic [NUM_KEYS-1:0]            pending;
    logic [NUM_VOICES-1:0]          v_valid;
    logic [NUM_VOICES-1:0][KW-1:0]  v_owner;
    logic [KW-1:0]                  k;
    logic                           ev;

    logic [KW-1:0]                  pend_idx;
    logic                           pend_found;
    logic [VW-1:0]                  free_idx;
    logic                           free_found;
    logic [VW-1:0]                  rel_idx;
    logic                           rel_found;

    assign pending     = keys_q ^ held;
    assign active_mask = v_valid;

    piano_prio_enc #(.W(NUM_KEYS), .IW(KW)) u_pend_enc (
        .req   (pending),
        .idx   (pend_idx),
        .found (pend_found)
    );

    piano_prio_enc #(.W(NUM_VOICES), .IW(VW)) u_free_enc (
        .req   (~v_valid),
        .idx   (free_idx),
        .found (free_found)
    );

    // A key owns at most one voice, so any match is the match.
    always_comb begin
        rel_idx   = '0;
        rel_found = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (v_valid[v] && v_owner[v] == k) begin
                rel_idx   = VW'(v);
                rel_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            keys_q     <= '0;
            held       <= '0;
            v_valid    <= '0;
            v_owner    <= '0;
            k          <= '0;
            ev         <= 1'b0;
            voice_req  <= 1'b0;
            voice_idx  <= '0;
            voice_div  <= '0;
            voice_gate <= 1'b0;
            busy       <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            keys_q  <= keys;
            dropped <= 1'b0;
            case (state)
                IDLE: begin
                    if (pend_found) begin
                        k     <= pend_idx;
                        ev    <= keys_q[pend_idx];
                        state <= FIND;
                        busy  <= 1'b1;
                    end
                end
                FIND: begin
                    if (ev) begin
                        if (free_found) begin
                            voice_idx  <= free_idx;
                            voice_div  <= DIV_W'(DIV_TABLE[k]);
                            voice_gate <= 1'b1;
                            voice_req  <= 1'b1;
                            state      <= REQ;
                        end else begin
                            // No voice left: accept the key so it is not retried.
                            dropped <= 1'b1;
                            held[k] <= 1'b1;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        if (rel_found) begin
                            voice_idx  <= rel_idx;
                            voice_div  <= '0;
                            voice_gate <= 1'b0;
                            voice_req  <= 1'b1;
                            state      <= REQ;
                        end else begin
                            held[k] <= 1'b0;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (voice_ack) begin
                        held[k]            <= voice_gate;
                        v_valid[voice_idx] <= voice_gate;
                        if (voice_gate)
                            v_owner[voice_idx] <= k;
                        voice_req <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
